// File: rtl/sum_accum_pkg.sv
// Shared datapath definitions: FSM state encoding and clog2 helper.
// Reused by datapath blocks that accumulate or buffer results.
package sum_accum_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_accum_stage.sv
// Accumulates NUM_SAMPLES adder sums (valid/ready in) and holds the total
// with a sticky overflow flag until taken (valid/ready out). Clk, Rst, clr.
module sum_accum_stage
  import sum_accum_pkg::*;
#(
  parameter int DATAWIDTH   = 2,
  parameter int ACCWIDTH    = 8,
  parameter int NUM_SAMPLES = 4,
  localparam int CNTW       = clog2(NUM_SAMPLES + 1)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                clr,
  input  logic [DATAWIDTH:0]  sum,
  input  logic                sum_valid,
  output logic                sum_ready,
  output logic [ACCWIDTH-1:0] acc,
  output logic                acc_valid,
  input  logic                acc_ready,
  output logic                ovf,
  output logic [CNTW-1:0]     count
);

  localparam logic [CNTW-1:0] LAST = CNTW'(NUM_SAMPLES - 1);

  state_t              state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                av_q, av_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                rdy_q;
  logic                accept;
  logic                complete;
  logic [ACCWIDTH:0]   nxt;

  // Extra bit keeps the carry out of the accumulator.
  assign nxt = {1'b0, acc_q} + (ACCWIDTH + 1)'(sum);

  assign sum_ready = rdy_q & (state_q == ACC) & ~clr;
  assign accept    = sum_valid & sum_ready;
  assign complete  = av_q & acc_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    av_d    = av_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      av_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            acc_d = nxt[ACCWIDTH-1:0];
            ovf_d = ovf_q | nxt[ACCWIDTH];
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == LAST) begin
              state_d = OUT;
              av_d    = 1'b1;
            end
          end
        end
        OUT: begin
          if (complete) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            av_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      av_q    <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      av_q    <= av_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  assign acc       = acc_q;
  assign acc_valid = av_q;
  assign ovf       = ovf_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_sum_accum_stage.sv
// Bench for sum_accum_stage: 8-bit and 4-bit accumulator instances
// share stimulus; checked against a queue-based sample model.
module tb_sum_accum_stage;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       clr = 1'b0;
  logic       sum_valid = 1'b0;
  logic       acc_ready = 1'b0;
  logic [2:0] sum = '0;

  logic       sr8, sr4;
  logic [7:0] acc8;
  logic [3:0] acc4;
  logic       av8, av4;
  logic       ovf8, ovf4;
  logic [2:0] cnt8, cnt4;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  q[$];
  bit  mout = 1'b0;
  bit  mrdy = 1'b0;
  bit  hold = 1'b0;

  always #5 Clk = ~Clk;

  sum_accum_stage #(
    .DATAWIDTH(2), .ACCWIDTH(8), .NUM_SAMPLES(4)
  ) u_dut8 (
    .Clk(Clk), .Rst(Rst), .clr(clr),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sr8),
    .acc(acc8), .acc_valid(av8), .acc_ready(acc_ready),
    .ovf(ovf8), .count(cnt8)
  );

  sum_accum_stage #(
    .DATAWIDTH(2), .ACCWIDTH(4), .NUM_SAMPLES(4)
  ) u_dut4 (
    .Clk(Clk), .Rst(Rst), .clr(clr),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sr4),
    .acc(acc4), .acc_valid(av4), .acc_ready(acc_ready),
    .ovf(ovf4), .count(cnt4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int t;
    t = 0;
    foreach (q[i]) t += q[i];
    chk("acc8", 32'(acc8), 32'(t % 256));
    chk("acc4", 32'(acc4), 32'(t % 16));
    chk("ovf8", 32'(ovf8), 32'(t >= 256));
    chk("ovf4", 32'(ovf4), 32'(t >= 16));
    chk("cnt8", 32'(cnt8), 32'(q.size()));
    chk("cnt4", 32'(cnt4), 32'(q.size()));
    chk("av8", 32'(av8), 32'(mout));
    chk("av4", 32'(av4), 32'(mout));
    chk("rdy8", 32'(sr8), 32'(mrdy && !mout && !clr));
    chk("rdy4", 32'(sr4), 32'(mrdy && !mout && !clr));
  endtask

  task automatic cycle(input bit v, input logic [2:0] s,
                       input bit ar, input bit c);
    bit acpt;
    sum_valid = v;
    sum       = v ? s : 3'bxxx;
    acc_ready = ar;
    clr       = c;
    @(negedge Clk);
    check_all();
    acpt = v && mrdy && !mout && !c;
    @(posedge Clk);
    if (c) begin
      q.delete();
      mout = 1'b0;
    end else if (acpt) begin
      q.push_back(int'(s));
      if (q.size() == 4) mout = 1'b1;
    end else if (mout && ar) begin
      q.delete();
      mout = 1'b0;
    end
    mrdy = 1'b1;
    hold = v && !acpt;
    #1;
  endtask

  task automatic do_reset();
    Rst       = 1'b0;
    sum_valid = 1'b0;
    acc_ready = 1'b0;
    clr       = 1'b0;
    #1;
    q.delete();
    mout = 1'b0;
    mrdy = 1'b0;
    hold = 1'b0;
    check_all();
    repeat (3) @(posedge Clk);
    #1;
    check_all();
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check_all();
    @(posedge Clk);
    #1;
    mrdy = 1'b1;
    check_all();
  endtask

  initial begin
    logic [2:0] rs;
    bit         rv;
    rs = '0;

    do_reset();

    cycle(1, 3'd1, 1, 0);
    cycle(1, 3'd2, 1, 0);
    cycle(1, 3'd3, 1, 0);
    cycle(1, 3'd4, 1, 0);
    cycle(0, 3'd0, 1, 0);
    cycle(0, 3'd0, 0, 0);

    cycle(1, 3'd1, 0, 0);
    cycle(1, 3'd2, 0, 0);
    cycle(1, 3'd3, 0, 0);
    cycle(1, 3'd4, 0, 0);
    repeat (5) cycle(1, 3'd7, 0, 0);
    cycle(1, 3'd7, 1, 0);
    cycle(1, 3'd7, 1, 0);
    cycle(0, 3'd0, 0, 1);

    cycle(1, 3'd7, 0, 0);
    cycle(1, 3'd7, 0, 0);
    cycle(1, 3'd7, 0, 0);
    cycle(1, 3'd1, 0, 0);
    cycle(0, 3'd0, 1, 0);
    cycle(0, 3'd0, 0, 0);

    cycle(1, 3'd5, 0, 0);
    cycle(0, 3'd0, 0, 0);
    cycle(0, 3'd0, 0, 0);
    cycle(1, 3'd1, 0, 0);
    cycle(0, 3'd0, 0, 0);
    cycle(1, 3'd2, 0, 0);
    cycle(1, 3'd3, 0, 0);
    cycle(0, 3'd0, 0, 0);
    cycle(0, 3'd0, 1, 0);

    cycle(1, 3'd3, 0, 0);
    cycle(1, 3'd3, 0, 0);
    cycle(0, 3'd0, 0, 1);
    repeat (4) cycle(1, 3'd1, 0, 0);
    cycle(0, 3'd0, 0, 0);
    cycle(0, 3'd0, 1, 1);
    cycle(0, 3'd0, 0, 0);
    repeat (4) cycle(1, 3'd1, 0, 0);
    cycle(0, 3'd0, 0, 0);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      if (hold) begin
        rv = 1'b1;
      end else begin
        rv = ($urandom_range(0, 9) < 7);
        rs = 3'($urandom_range(0, 7));
      end
      cycle(rv, rs, bit'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sum_accum_stage.md
Name: sum_accum_stage

Overview:
- Registered stage directly downstream of the combinational adder. It consumes the adder's `sum` output through a valid/ready handshake.
- It accumulates NUM_SAMPLES accepted sums into a wider register, then presents the total with a sticky overflow flag.
- It holds the total until the consumer takes it, then restarts.
- It registers the adder's combinational result, which breaks the adder's combinational path before downstream logic.

Parameters:
- DATAWIDTH, 2, input sum is DATAWIDTH+1 bits ([DATAWIDTH:0]), matching the adder output width.
- ACCWIDTH, 8, accumulator width in bits; must be >= DATAWIDTH+1.
- NUM_SAMPLES, 4, sums per result; must be >= 1.
- CNTW, clog2(NUM_SAMPLES+1), sample counter width (derived, not overridden).

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear, highest priority after Rst.
- sum  input  DATAWIDTH+1  sum from the adder, unsigned.
- sum_valid  input  1  sum is valid this cycle.
- sum_ready  output  1  stage accepts sum this cycle.
- acc  output  ACCWIDTH  accumulated total, unsigned.
- acc_valid  output  1  acc holds a completed result.
- acc_ready  input  1  consumer takes acc this cycle.
- ovf  output  1  sticky: carry out of ACCWIDTH during this result.
- count  output  CNTW  samples accepted toward the current result.

Behaviour:
- Reset (Rst low, async): state=ACC, acc=0, acc_valid=0, ovf=0, count=0, rdy_q=0.
- While Rst is low, sum_ready=0. rdy_q goes to 1 on the first Clk edge after Rst goes high.
- sum_ready = rdy_q & (state==ACC) & ~clr. This is combinational from registers and clr only; it never depends on sum_valid.
- Accept = sum_valid & sum_ready. Complete = acc_valid & acc_ready.
- State ACC, on accept:
  - acc <= low ACCWIDTH bits of (acc + zero-extended sum), computed at ACCWIDTH+1 bits.
  - ovf <= ovf | carry bit.
  - count <= count+1.
  - If count == NUM_SAMPLES-1: state <= OUT, acc_valid <= 1.
- State ACC, no accept: all registers hold.
- State OUT: sum_ready=0; acc, ovf and count are stable and acc_valid=1.
  - On complete: state <= ACC, acc <= 0, ovf <= 0, count <= 0, acc_valid <= 0.
  - The next sample can be accepted in the cycle after the complete.
- Latency: acc_valid rises on the Clk edge that accepts the NUM_SAMPLES-th sum. The result is visible in the following cycle.
- Throughput: one result per NUM_SAMPLES+1 cycles at best. The OUT state always costs at least one cycle.
- NUM_SAMPLES=1: every accept moves to OUT with acc = zero-extended sum.
- Wrap-around: acc wraps modulo 2^ACCWIDTH. ovf marks the wrap and stays set until the result completes, clr, or Rst.
- clr=1 on any Clk edge: state=ACC, acc=0, ovf=0, count=0, acc_valid=0.
  - A sum presented in the same cycle is not accepted (sum_ready is 0).
  - A pending result in OUT is discarded.
- Simultaneous clr and acc_ready in OUT: clr wins; this is not counted as a complete.
- Rst asserted mid-accumulation or in OUT: immediate return to reset values; the partial or pending result is lost.
- sum is sampled only on accept. An X on sum while sum_ready=0 must not propagate into acc.
- Protocol rule for the upstream: after sum_valid is raised, it stays high and sum stays stable until accept. The stage does not check this rule.

Decomposition:
- Shared include header: state encodings ACC=1'b0 and OUT=1'b1, plus a clog2 constant function. Other datapath blocks in the codebase reuse these.
- No sub-module. The accumulate adder is inline at ACCWIDTH+1 bits so the carry is kept.
- Do not reuse the existing adder module for the accumulate adder: it has no carry output.

Test Plan:
- Reset: hold Rst low 3 cycles -> acc=0, acc_valid=0, ovf=0, count=0, sum_ready=0. Release Rst -> sum_ready=1 after the first Clk edge.
- Back-to-back (DATAWIDTH=2, ACCWIDTH=8, N=4): sums 1,2,3,4 with acc_ready=1 -> acc_valid=1 the cycle after the 4th accept, acc=10, ovf=0. acc_valid=0 one cycle later, count=0.
- Backpressure: after a result, hold acc_ready=0 for 5 cycles with sum_valid=1, sum=7 -> sum_ready=0 throughout, acc stays 10. Raise acc_ready -> next accumulation starts from 0.
- Overflow (ACCWIDTH=4, N=4): sums 7,7,7,1 -> acc=6 (22 mod 16), ovf=1. After complete -> ovf=0.
- Gapped input: sum_valid pattern 1,0,0,1,0,1,1 with sums 5,x,x,1,x,2,3 -> only 4 accepts, acc=11, no X in acc.
- clr/Rst mid-op: after sums 3,3 assert clr 1 cycle -> count=0, acc=0. Then sums 1,1,1,1 -> acc=4. Assert Rst while in OUT -> acc_valid drops immediately.
